// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and the program-loader state encoding
package mips_pkg;
  localparam int INSTR_W = 16;
  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam logic [3:0] HALT = 4'h9;
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_CNT,
    LD_ADDR,
    LD_HI,
    LD_LO,
    LD_CHK
  } ld_state_e;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to instruction-memory writes, holds the core in reset until checksum passes
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter logic [7:0] HDR = HDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_rst,
  output logic               done,
  output logic               err
);
  ld_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d, xor_q, xor_d, hi_q, hi_d;
  logic [ADDR_W-1:0] cur_q, cur_d, addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic ready_q, ready_d, we_q, we_d, core_rst_q, core_rst_d, done_q, done_d, err_q, err_d;
  logic fire;
  assign fire = in_valid && ready_q;
  // frame parser: one byte per handshake, running XOR over everything after the header
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    xor_d = xor_q;
    hi_d = hi_q;
    cur_d = cur_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b1;
    we_d = 1'b0;
    core_rst_d = core_rst_q;
    done_d = done_q;
    err_d = err_q;
    if (fire) begin
      case (state_q)
        LD_IDLE: if (in_data == HDR) begin
          state_d = LD_CNT;
          core_rst_d = 1'b1;
          done_d = 1'b0;
          err_d = 1'b0;
        end
        LD_CNT: begin
          cnt_d = in_data;
          xor_d = in_data;
          state_d = LD_ADDR;
        end
        LD_ADDR: begin
          cur_d = ADDR_W'(in_data);
          xor_d = xor_q ^ in_data;
          state_d = (cnt_q != 8'd0) ? LD_HI : LD_CHK;
        end
        LD_HI: begin
          hi_d = in_data;
          xor_d = xor_q ^ in_data;
          state_d = LD_LO;
        end
        LD_LO: begin
          we_d = 1'b1;
          addr_d = cur_q;
          wdata_d = {hi_q, in_data};
          cur_d = cur_q + 1'b1;
          cnt_d = cnt_q - 8'd1;
          xor_d = xor_q ^ in_data;
          state_d = (cnt_q == 8'd1) ? LD_CHK : LD_HI;
        end
        LD_CHK: begin
          done_d = (in_data == xor_q);
          err_d = (in_data != xor_q);
          core_rst_d = (in_data != xor_q);
          state_d = LD_IDLE;
        end
        default: state_d = LD_IDLE;
      endcase
    end
  end
  // state and output registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LD_IDLE;
      cnt_q <= '0;
      xor_q <= '0;
      hi_q <= '0;
      cur_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q <= 1'b0;
      core_rst_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      xor_q <= xor_d;
      hi_q <= hi_d;
      cur_q <= cur_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      we_q <= we_d;
      core_rst_q <= core_rst_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign in_ready = ready_q;
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst = core_rst_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for the program loader
module tb_imem_loader;
  import mips_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, imem_we, core_rst, done, err;
  logic [7:0] imem_addr;
  logic [15:0] imem_wdata;
  int checks = 0;
  int errors = 0;
  bit bub = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] e;
  logic [15:0] prog [8] = '{16'hB2C9, 16'hB508, 16'h0734, 16'h4382, 16'h9000, 16'h0, 16'h0, 16'h0};
  logic [15:0] wrap [8] = '{16'h1234, 16'h5678, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  logic [15:0] none [8] = '{default: 16'h0};

  imem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (exp_q.size() > 0) begin
        if (imem_we) begin
          e = exp_q.pop_front();
          check("write", {8'h0, imem_addr, imem_wdata}, {8'h0, e});
        end
      end else begin
        check("spurious_we", 32'(imem_we), 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    if (bub) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cnt, input logic [7:0] adr, input logic [15:0] w [8], input bit bad);
    logic [7:0] x;
    logic [7:0] a;
    send(HDR_DEFAULT);
    check("core_rst_on_hdr", 32'(core_rst), 32'd1);
    check("done_clr_on_hdr", 32'(done), 32'd0);
    check("err_clr_on_hdr", 32'(err), 32'd0);
    send(cnt);
    send(adr);
    x = cnt ^ adr;
    a = adr;
    for (int i = 0; i < int'(cnt); i++) begin
      send(w[i][15:8]);
      exp_q.push_back({a, w[i]});
      send(w[i][7:0]);
      x = x ^ w[i][15:8] ^ w[i][7:0];
      a = a + 8'd1;
    end
    send(bad ? (x ^ 8'h01) : x);
    check("done", 32'(done), bad ? 32'd0 : 32'd1);
    check("err", 32'(err), bad ? 32'd1 : 32'd0);
    check("core_rst", 32'(core_rst), bad ? 32'd1 : 32'd0);
    check("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", 32'(imem_wdata), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);
    send(8'h00);
    send(8'h3C);
    check("idle_filter_core_rst", 32'(core_rst), 32'd1);
    send_frame(8'd5, 8'h01, prog, 1'b0);
    send_frame(8'd5, 8'h01, prog, 1'b1);
    send_frame(8'd2, 8'hFF, wrap, 1'b0);
    send_frame(8'd0, 8'h07, none, 1'b0);
    send_frame(8'd0, 8'h07, none, 1'b1);
    send(HDR_DEFAULT);
    send(8'h03);
    send(8'h10);
    exp_q.push_back({8'h10, 16'h1111});
    send(8'h11);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_in_ready", 32'(in_ready), 32'd0);
    check("mid_we", 32'(imem_we), 32'd0);
    check("mid_addr", 32'(imem_addr), 32'd0);
    check("mid_wdata", 32'(imem_wdata), 32'd0);
    check("mid_core_rst", 32'(core_rst), 32'd1);
    check("mid_done", 32'(done), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_one_word", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'd5, 8'h01, prog, 1'b0);
    send_frame(8'd0, 8'h07, none, 1'b0);
    bub = 1'b1;
    send_frame(8'd5, 8'h01, prog, 1'b0);
    send_frame(8'd5, 8'h01, prog, 1'b1);
    send_frame(8'd2, 8'hFF, wrap, 1'b0);
    bub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("final_writes_left", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
